// File: rtl/int_scheduler.sv
// ----------------------------------------------------------------------------
// int_scheduler
// Sequencer/arbiter between the interrupt request/attention registers and the
// core's PC logic. Selects the highest-priority eligible pending line, decides
// when the core may be redirected (including strictly-higher-priority nested
// preemption), drives the one-hot set/clear strobes into the interrupt
// registers and keeps a LIFO of return addresses for nested service.
//
// Ports
//   i_clk            system clock, all state on rising edge
//   i_reset          synchronous active-low reset
//   i_int_pend       pending requests (request register)
//   i_int_srv        in-service lines (attention register)
//   i_mask_we/_d     load per-line enable mask
//   i_gie_set/_clr   global enable set / clear (clear wins)
//   i_instr_boundary core can be redirected this cycle
//   i_reti_op        core executes return-from-interrupt this cycle
//   i_pc_next        return address to push on a take
//   o_s_calli        one-hot set-attention strobe
//   o_s_reti         one-hot clear request+attention strobe
//   o_irq_take       core loads PC from o_vec_addr
//   o_vec_addr       vector address of the taken line
//   o_ret_valid      core loads PC from o_ret_pc
//   o_ret_pc         popped return address
//   o_int_mask       current mask register
//   o_gie            current global enable
//   o_depth          return-stack occupancy
//   o_err            pulse on reti with empty stack
// ----------------------------------------------------------------------------
module int_scheduler #(
    parameter int              WIDTH    = 8,
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] VEC_BASE = 10'b1000000000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_int_pend,
    input  logic [WIDTH-1:0] i_int_srv,
    input  logic             i_mask_we,
    input  logic [WIDTH-1:0] i_mask_d,
    input  logic             i_gie_set,
    input  logic             i_gie_clr,
    input  logic             i_instr_boundary,
    input  logic             i_reti_op,
    input  logic [PC_W-1:0]  i_pc_next,
    output logic [WIDTH-1:0] o_s_calli,
    output logic [WIDTH-1:0] o_s_reti,
    output logic             o_irq_take,
    output logic [PC_W-1:0]  o_vec_addr,
    output logic             o_ret_valid,
    output logic [PC_W-1:0]  o_ret_pc,
    output logic [WIDTH-1:0] o_int_mask,
    output logic             o_gie,
    output logic [3:0]       o_depth,
    output logic             o_err
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALL = 2'd1,
        ST_RET  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Index of the highest set bit; caller qualifies with a separate "any" flag.
    function automatic logic [IDX_W-1:0] f_msb_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [WIDTH-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        return {{(WIDTH-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_mask;
    logic                   r_gie;
    logic [3:0]             r_depth;
    logic [PC_W-1:0]        r_stack [WIDTH];
    logic [WIDTH-1:0]       r_s_calli;
    logic [WIDTH-1:0]       r_s_reti;
    logic                   r_irq_take;
    logic                   r_ret_valid;
    logic                   r_err;
    logic [PC_W-1:0]        r_vec_addr;
    logic [PC_W-1:0]        r_ret_pc;

    logic [WIDTH-1:0]       w_elig;
    logic [IDX_W-1:0]       w_sel;
    logic [IDX_W-1:0]       w_cur;
    logic                   w_srv_any;
    logic                   w_take;
    logic [IDX_W-1:0]       w_top_idx;
    logic [IDX_W-1:0]       w_push_idx;
    logic [PC_W-1:0]        w_vec;
    logic                   w_push;
    logic                   w_pop;
    logic [WIDTH-1:0]       w_s_calli_nxt;
    logic [WIDTH-1:0]       w_s_reti_nxt;
    logic                   w_irq_take_nxt;
    logic                   w_ret_valid_nxt;
    logic                   w_err_nxt;

    assign w_elig     = i_int_pend & r_mask & ~i_int_srv;
    assign w_sel      = f_msb_idx(w_elig);
    assign w_cur      = f_msb_idx(i_int_srv);
    assign w_srv_any  = |i_int_srv;
    // No line in service counts as priority -1, so any eligible line beats it.
    assign w_take     = r_gie & i_instr_boundary & (|w_elig)
                      & (~w_srv_any | (w_sel > w_cur))
                      & (r_depth < 4'(WIDTH));
    assign w_top_idx  = IDX_W'(r_depth - 4'd1);
    assign w_push_idx = IDX_W'(r_depth);
    assign w_vec      = VEC_BASE + PC_W'(WIDTH - 1) - PC_W'(w_sel);

    // Next-state and next-strobe decode. Strobes are computed on the decision
    // cycle and registered so they appear during the CALL/RET state.
    always_comb begin
        w_state_nxt     = r_state;
        w_s_calli_nxt   = {WIDTH{1'b0}};
        w_s_reti_nxt    = {WIDTH{1'b0}};
        w_irq_take_nxt  = 1'b0;
        w_ret_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_reti_op) begin
                    w_state_nxt = ST_RET;
                    if (r_depth != 4'd0) begin
                        w_ret_valid_nxt = 1'b1;
                        w_s_reti_nxt    = w_srv_any ? f_onehot(w_cur) : {WIDTH{1'b0}};
                        w_pop           = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_take) begin
                    w_state_nxt    = ST_CALL;
                    w_irq_take_nxt = 1'b1;
                    w_s_calli_nxt  = f_onehot(w_sel);
                    w_push         = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALL: w_state_nxt = ST_HOLD;
            ST_RET:  w_state_nxt = ST_HOLD;
            ST_HOLD: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, strobes, depth, configuration and address outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_mask      <= {WIDTH{1'b0}};
            r_gie       <= 1'b0;
            r_depth     <= 4'd0;
            r_s_calli   <= {WIDTH{1'b0}};
            r_s_reti    <= {WIDTH{1'b0}};
            r_irq_take  <= 1'b0;
            r_ret_valid <= 1'b0;
            r_err       <= 1'b0;
            r_vec_addr  <= {PC_W{1'b0}};
            r_ret_pc    <= {PC_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_s_calli   <= w_s_calli_nxt;
            r_s_reti    <= w_s_reti_nxt;
            r_irq_take  <= w_irq_take_nxt;
            r_ret_valid <= w_ret_valid_nxt;
            r_err       <= w_err_nxt;
            if (i_mask_we) begin
                r_mask <= i_mask_d;
            end
            if (i_gie_clr) begin
                r_gie <= 1'b0;
            end else if (i_gie_set) begin
                r_gie <= 1'b1;
            end
            if (w_push) begin
                r_depth    <= r_depth + 4'd1;
                r_vec_addr <= w_vec;
            end else if (w_pop) begin
                r_depth  <= r_depth - 4'd1;
                r_ret_pc <= r_stack[w_top_idx];
            end
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge i_clk) begin
        if (w_push && i_reset) begin
            r_stack[w_push_idx] <= i_pc_next;
        end
    end

    assign o_s_calli   = r_s_calli;
    assign o_s_reti    = r_s_reti;
    assign o_irq_take  = r_irq_take;
    assign o_vec_addr  = r_vec_addr;
    assign o_ret_valid = r_ret_valid;
    assign o_ret_pc    = r_ret_pc;
    assign o_int_mask  = r_mask;
    assign o_gie       = r_gie;
    assign o_depth     = r_depth;
    assign o_err       = r_err;

endmodule

// File: tb/tb_int_scheduler.sv
// ----------------------------------------------------------------------------
// tb_int_scheduler
// Scoreboard bench for int_scheduler: each decision cycle pushes the strobe
// record it should produce; a negedge monitor pops and compares whenever the
// DUT raises any strobe. Static state (depth, gie, mask) is checked directly.
// ----------------------------------------------------------------------------
module tb_int_scheduler;

    logic       clk;
    logic       reset;
    logic [7:0] int_pend;
    logic [7:0] int_srv;
    logic       mask_we;
    logic [7:0] mask_d;
    logic       gie_set;
    logic       gie_clr;
    logic       instr_boundary;
    logic       reti_op;
    logic [9:0] pc_next;
    logic [7:0] s_calli;
    logic [7:0] s_reti;
    logic       irq_take;
    logic [9:0] vec_addr;
    logic       ret_valid;
    logic [9:0] ret_pc;
    logic [7:0] int_mask;
    logic       gie;
    logic [3:0] depth;
    logic       err;

    typedef struct {
        logic [7:0] calli;
        logic [7:0] reti;
        logic       take;
        logic       rv;
        logic       er;
        logic [9:0] vec;
        logic [9:0] rpc;
        logic [3:0] dep;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    int_scheduler dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_int_pend       (int_pend),
        .i_int_srv        (int_srv),
        .i_mask_we        (mask_we),
        .i_mask_d         (mask_d),
        .i_gie_set        (gie_set),
        .i_gie_clr        (gie_clr),
        .i_instr_boundary (instr_boundary),
        .i_reti_op        (reti_op),
        .i_pc_next        (pc_next),
        .o_s_calli        (s_calli),
        .o_s_reti         (s_reti),
        .o_irq_take       (irq_take),
        .o_vec_addr       (vec_addr),
        .o_ret_valid      (ret_valid),
        .o_ret_pc         (ret_pc),
        .o_int_mask       (int_mask),
        .o_gie            (gie),
        .o_depth          (depth),
        .o_err            (err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, leaving the bench 1 ns after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle decision pulse followed by the CALL/RET + HOLD recovery.
    task automatic decide(input logic bnd, input logic rti);
        instr_boundary = bnd;
        reti_op        = rti;
        step(1);
        instr_boundary = 1'b0;
        reti_op        = 1'b0;
        step(3);
    endtask

    task automatic push_take(input logic [7:0] c, input logic [9:0] v, input logic [3:0] d);
        exp_t e;
        e = '{calli: c, reti: 8'h00, take: 1'b1, rv: 1'b0, er: 1'b0, vec: v, rpc: 10'h000, dep: d};
        sb_q.push_back(e);
    endtask

    task automatic push_ret(input logic [7:0] r, input logic [9:0] p, input logic [3:0] d);
        exp_t e;
        e = '{calli: 8'h00, reti: r, take: 1'b0, rv: 1'b1, er: 1'b0, vec: 10'h000, rpc: p, dep: d};
        sb_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = '{calli: 8'h00, reti: 8'h00, take: 1'b0, rv: 1'b0, er: 1'b1, vec: 10'h000, rpc: 10'h000, dep: 4'd0};
        sb_q.push_back(e);
    endtask

    // Monitor: any strobe must match the oldest expected record.
    always @(negedge clk) begin
        exp_t e;
        if (irq_take || ret_valid || err || (s_calli != 8'h00) || (s_reti != 8'h00)) begin
            if (sb_q.size() == 0) begin
                chk_eq("unexpected_strobe", {s_calli, s_reti, 13'd0, irq_take, ret_valid, err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk_eq("irq_take",  32'(irq_take),  32'(e.take));
                chk_eq("s_calli",   32'(s_calli),   32'(e.calli));
                chk_eq("s_reti",    32'(s_reti),    32'(e.reti));
                chk_eq("ret_valid", 32'(ret_valid), 32'(e.rv));
                chk_eq("err",       32'(err),       32'(e.er));
                chk_eq("depth",     32'(depth),     32'(e.dep));
                if (e.take) chk_eq("vec_addr", 32'(vec_addr), 32'(e.vec));
                if (e.rv)   chk_eq("ret_pc",   32'(ret_pc),   32'(e.rpc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; int_pend = 8'h00; int_srv = 8'h00; mask_we = 1'b0; mask_d = 8'h00;
        gie_set = 1'b0; gie_clr = 1'b0; instr_boundary = 1'b0; reti_op = 1'b0; pc_next = 10'h000;
        step(2);
        chk_eq("rst_irq_take", 32'(irq_take), 32'd0);
        chk_eq("rst_strobes",  32'({s_calli, s_reti, ret_valid, err}), 32'd0);
        chk_eq("rst_vec",      32'(vec_addr), 32'd0);
        chk_eq("rst_ret_pc",   32'(ret_pc),   32'd0);
        chk_eq("rst_depth",    32'(depth),    32'd0);
        chk_eq("rst_gie",      32'(gie),      32'd0);
        chk_eq("rst_mask",     32'(int_mask), 32'd0);

        // Configure
        reset = 1'b1; mask_we = 1'b1; mask_d = 8'hFF; gie_set = 1'b1;
        step(1);
        mask_we = 1'b0; gie_set = 1'b0;
        chk_eq("cfg_mask", 32'(int_mask), 32'hFF);
        chk_eq("cfg_gie",  32'(gie),      32'd1);

        // Basic take of line 2
        int_pend = 8'h04; pc_next = 10'h012;
        push_take(8'h04, 10'h205, 4'd1);
        decide(1'b1, 1'b0);
        int_srv = 8'h04;

        // Nested preemption by line 5
        int_pend = 8'h24; pc_next = 10'h033;
        push_take(8'h20, 10'h202, 4'd2);
        decide(1'b1, 1'b0);
        int_srv = 8'h24;

        // Lower line 1 must not preempt
        int_pend = 8'h26;
        decide(1'b1, 1'b0);
        chk_eq("nopreempt_depth", 32'(depth), 32'd2);

        // Return from line 5
        push_ret(8'h20, 10'h033, 4'd1);
        decide(1'b0, 1'b1);
        int_srv = 8'h04; int_pend = 8'h06;

        // reti and take condition together: return wins
        int_pend = 8'h86;
        push_ret(8'h04, 10'h012, 4'd0);
        decide(1'b1, 1'b1);
        int_srv = 8'h00;
        chk_eq("conflict_depth", 32'(depth), 32'd0);

        // Priority: lines 7 and 0 together
        int_pend = 8'h81; pc_next = 10'h055;
        push_take(8'h80, 10'h200, 4'd1);
        decide(1'b1, 1'b0);
        int_srv = 8'h80;
        decide(1'b1, 1'b0);
        chk_eq("line0_waits", 32'(depth), 32'd1);
        push_ret(8'h80, 10'h055, 4'd0);
        decide(1'b0, 1'b1);
        int_srv = 8'h00; int_pend = 8'h01;

        // reti on empty stack
        push_err();
        decide(1'b0, 1'b1);

        // gie_clr wins over gie_set
        gie_set = 1'b1; gie_clr = 1'b1;
        step(1);
        gie_set = 1'b0; gie_clr = 1'b0;
        chk_eq("gie_clr_wins", 32'(gie), 32'd0);
        decide(1'b1, 1'b0);
        chk_eq("gie_off_notake", 32'(depth), 32'd0);
        gie_set = 1'b1;
        step(1);
        gie_set = 1'b0;

        // Masked line cannot be taken
        mask_we = 1'b1; mask_d = 8'hFE;
        step(1);
        mask_we = 1'b0;
        chk_eq("mask_load", 32'(int_mask), 32'hFE);
        decide(1'b1, 1'b0);
        chk_eq("masked_notake", 32'(depth), 32'd0);
        mask_we = 1'b1; mask_d = 8'hFF;
        step(1);
        mask_we = 1'b0;

        // Reset asserted during the CALL cycle
        pc_next = 10'h077;
        push_take(8'h01, 10'h207, 4'd1);
        instr_boundary = 1'b1;
        step(1);
        instr_boundary = 1'b0;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk_eq("rstcall_take",  32'(irq_take), 32'd0);
        chk_eq("rstcall_calli", 32'(s_calli),  32'd0);
        chk_eq("rstcall_depth", 32'(depth),    32'd0);
        chk_eq("rstcall_gie",   32'(gie),      32'd0);
        chk_eq("rstcall_mask",  32'(int_mask), 32'd0);
        step(4);

        chk_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
